// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
//   Round-robin scheduler that shares one external combinational fixed-point
//   multiplier between NUM_REQ requesters. It has two pipeline stages:
//     S1 registers the granted operands (mul_a/mul_b) and the requester id.
//     S2 registers mul_result together with that id (resp_data/resp_id).
//   Backpressure from resp_ready stalls S2 first, then S1, and finally
//   deasserts req_ready. The block does no arithmetic. Product width,
//   scaling and truncation belong to the external multiplier.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b        packed operands, requester i in [i*W +: W]
//   mul_a, mul_b        registered operands to the shared multiplier
//   mul_result          combinational product from the shared multiplier
//   resp_valid/ready    result handshake
//   resp_data, resp_id  registered product and the id of its owner
//   busy                an operation is in S1 or S2
//   op_count,
//   stall_count         saturating statistics counters; present only when
//                       MULT_RR_ARBITER_STATS_EN is defined

// Per-requester operand gate. The muxed operand is the OR of all gated
// lanes. Because the grant is one-hot, that OR is exact.
module mult_rr_lane #(
  parameter int W = 25
) (
  input  logic         gnt,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a_m,
  output logic [W-1:0] b_m
);
  assign a_m = a & {W{gnt}};
  assign b_m = b & {W{gnt}};
endmodule

module mult_rr_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int ENGINE_DATA_WIDTH  = 25,
  parameter int ENGINE_FRACT_WIDTH = 20,
  parameter int ID_WIDTH           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ENGINE_DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ENGINE_DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ENGINE_DATA_WIDTH-1:0]   mul_a,
  output logic [ENGINE_DATA_WIDTH-1:0]   mul_b,
  input  logic [ENGINE_DATA_WIDTH-1:0]   mul_result,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ENGINE_DATA_WIDTH-1:0]   resp_data,
  output logic [ID_WIDTH-1:0]            resp_id,
`ifdef MULT_RR_ARBITER_STATS_EN
  output logic [15:0]                    op_count,
  output logic [15:0]                    stall_count,
`endif
  output logic                           busy
);

  localparam int W      = ENGINE_DATA_WIDTH;
  localparam int STAGES = 2;

  // Elaboration-time sanity checks on the parameters.
  if (NUM_REQ < 1) begin : g_chk_req
    $error("mult_rr_arbiter: NUM_REQ must be >= 1");
  end
  if (ENGINE_FRACT_WIDTH >= ENGINE_DATA_WIDTH) begin : g_chk_fw
    $error("mult_rr_arbiter: ENGINE_FRACT_WIDTH must be < ENGINE_DATA_WIDTH");
  end

  typedef struct packed {
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic [ID_WIDTH-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]        data;
    logic [ID_WIDTH-1:0] id;
  } s2_t;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (resp_valid)
  logic [STAGES:1]             vld_pipe;
  s1_t                         s1;
  s2_t                         s2;
  logic [ID_WIDTH-1:0]         ptr;

  logic [NUM_REQ-1:0][W-1:0]   a_v, b_v, a_m, b_m;
  logic [W-1:0]                sel_a, sel_b;
  logic [NUM_REQ-1:0]          gnt;
  logic [ID_WIDTH-1:0]         gnt_id, ptr_nxt;
  logic                        found, acc, s2_adv, s1_free;

  assign a_v = req_a;
  assign b_v = req_b;

  // S2 takes a new product when it is empty or is being drained this cycle.
  assign s2_adv  = vld_pipe[1] & (~vld_pipe[2] | resp_ready);
  assign s1_free = ~vld_pipe[1] | s2_adv;

  // Round-robin search starting at ptr. This path depends only on
  // req_valid and the pipeline state, never on the operand values.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_WIDTH'(idx);
      end
    end
  end

  assign gnt       = (s1_free && found) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign req_ready = gnt;
  assign acc       = |gnt;
  assign ptr_nxt   = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mult_rr_lane #(.W(W)) u_lane (
      .gnt (gnt[i]),
      .a   (a_v[i]),
      .b   (b_v[i]),
      .a_m (a_m[i]),
      .b_m (b_m[i])
    );
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | a_m[i];
      sel_b = sel_b | b_m[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      ptr      <= '0;
    end else begin
      // S1: load on accept; otherwise empty out when the op moves to S2.
      if (acc) begin
        s1.a        <= sel_a;
        s1.b        <= sel_b;
        s1.id       <= gnt_id;
        vld_pipe[1] <= 1'b1;
        ptr         <= ptr_nxt;
      end else if (s2_adv) begin
        vld_pipe[1] <= 1'b0;
      end
      // S2: hold steady under backpressure so data and id stay stable.
      if (s2_adv) begin
        s2.data     <= mul_result;
        s2.id       <= s1.id;
        vld_pipe[2] <= 1'b1;
      end else if (resp_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  assign mul_a      = s1.a;
  assign mul_b      = s1.b;
  assign resp_valid = vld_pipe[2];
  assign resp_data  = s2.data;
  assign resp_id    = s2.id;
  assign busy       = vld_pipe[1] | vld_pipe[2];

`ifdef MULT_RR_ARBITER_STATS_EN
  // Both counters saturate and never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (s2_adv && op_count != 16'hFFFF)
        op_count <= op_count + 1'b1;
      if (vld_pipe[2] && !resp_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 1'b1;
    end
  end
`else
  // Statistics disabled: no counters.
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 25;
  localparam int FW = 20;
  localparam int IW = 2;

  logic               clk, rst;
  logic [N-1:0]       req_valid, req_ready;
  logic [N*W-1:0]     req_a, req_b;
  logic [W-1:0]       mul_a, mul_b, mul_result;
  logic               resp_valid, resp_ready, busy;
  logic [W-1:0]       resp_data;
  logic [IW-1:0]      resp_id;
`ifdef MULT_RR_ARBITER_STATS_EN
  logic [15:0]        op_count, stall_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  mult_rr_arbiter #(.NUM_REQ(N), .ENGINE_DATA_WIDTH(W), .ENGINE_FRACT_WIDTH(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
`ifdef MULT_RR_ARBITER_STATS_EN
    .op_count   (op_count),
    .stall_count(stall_count),
`endif
    .busy       (busy)
  );

  // External shared multiplier: signed Q4.20, truncating.
  logic signed [2*W-1:0] prod;
  assign prod       = (2*W)'($signed(mul_a)) * (2*W)'($signed(mul_b));
  assign mul_result = prod[FW+W-1:FW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    #3;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_mul_a",      32'(mul_a),      32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_resp_id",    32'(resp_id),    32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    #9 rst = 1'b0;                       // t=12, between edges
    step();

    // Full contention: grants 0,1,2,3,0,1,2,3, one result per cycle
    for (int i = 0; i < N; i++) set_op(i, W'((i + 1) << 20), W'(2 << 20));
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) check("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      step();
      if (c >= 1 && c <= 8) begin
        check("rr_valid", 32'(resp_valid), 32'd1);
        check("rr_id",    32'(resp_id),    32'((c - 1) % 4));
        check("rr_data",  32'(resp_data),  32'(((c - 1) % 4 + 1) * 32'h200000));
      end
      if (c == 9) check("rr_idle", 32'(resp_valid), 32'd0);
    end

    // Single op from requester 2: 1.5 * 2.0 = 3.0
    set_op(2, 25'h180000, 25'h200000);
    req_valid = 4'b0100;
    #1 check("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("single_s1_valid", 32'(resp_valid), 32'd0);
    check("single_mul_a",    32'(mul_a),      32'h180000);
    check("single_busy",     32'(busy),       32'd1);
    step();
    check("single_valid", 32'(resp_valid), 32'd1);
    check("single_data",  32'(resp_data),  32'h300000);
    check("single_id",    32'(resp_id),    32'd2);
    step();
    check("single_drain", 32'(resp_valid), 32'd0);

    // Pointer wrap and skip: ptr=3, only requester 1 valid
    req_valid = 4'b0010;
    #1 check("wrap_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0101;                 // ptr now 2
    #1 check("skip_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("skip_s2_id", 32'(resp_id), 32'd1);
    step();
    check("skip_s2_id2", 32'(resp_id), 32'd2);
    step();
    check("skip_idle", 32'(busy), 32'd0);

    // Backpressure: two ops in flight, consumer stalls 5 cycles
    resp_ready = 1'b0;
    set_op(0, 25'h100000, 25'h300000);   // 1.0 * 3.0
    set_op(3, 25'h1F00000, 25'h080000);  // -1.0 * 0.5
    req_valid = 4'b0001;
    #1 check("bp_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    #1 check("bp_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready0", 32'(req_ready),  32'd0);
      check("bp_valid",  32'(resp_valid), 32'd1);
      check("bp_data",   32'(resp_data),  32'h300000);
      check("bp_id",     32'(resp_id),    32'd0);
      check("bp_s1full", 32'(mul_a),      32'h1F00000);
      step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    #1;
    check("bp_first_data", 32'(resp_data), 32'h300000);
    step();
    check("bp_second_valid", 32'(resp_valid), 32'd1);
    check("bp_second_data",  32'(resp_data),  32'h1F80000);
    check("bp_second_id",    32'(resp_id),    32'd3);
    step();
    check("bp_done", 32'(busy), 32'd0);

    // Reset mid-operation with S1 and S2 full (ptr ends at 3 beforehand)
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    #1 check("mr_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0100;
    #1 check("mr_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    #1 check("mr_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_resp_valid", 32'(resp_valid), 32'd0);
    check("mr_busy",       32'(busy),       32'd0);
    check("mr_resp_data",  32'(resp_data),  32'd0);
    rst = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    #1 check("mr_ptr0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    step();
    check("mr_idle", 32'(busy), 32'd0);

`ifdef MULT_RR_ARBITER_STATS_EN
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    check("st_rst_op", 32'(op_count), 32'd0);
    resp_ready = 1'b0;
    req_valid = 4'b0001; step();
    req_valid = 4'b0010; step();         // op 1 enters S2
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();  // 4 stall cycles
    resp_ready = 1'b1;
    step();                              // op 2
    step();
    req_valid = 4'b0100; step();
    req_valid = '0; step();              // op 3
    step();
    check("st_op_count",    32'(op_count),    32'd3);
    check("st_stall_count", 32'(stall_count), 32'd4);
    force dut.op_count = 16'hFFFF;
    force dut.stall_count = 16'hFFFF;
    #1;
    release dut.op_count;
    release dut.stall_count;
    resp_ready = 1'b0;
    req_valid = 4'b0001; step();
    req_valid = '0; step();
    step();
    check("st_op_sat",    32'(op_count),    32'hFFFF);
    check("st_stall_sat", 32'(stall_count), 32'hFFFF);
    resp_ready = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Shares one combinational fixed-point multiplier (signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH, truncating) between NUM_REQ requesters.
- Requesters use valid/ready; arbitration is round-robin.
- Operands are registered into the multiplier and the product is registered out with the requester ID, giving a 2-stage pipeline with backpressure.
- Sits between the engine's compute units and the single shared multiplier instance; the multiplier is external, driven through the mul_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- ENGINE_DATA_WIDTH, 25, operand/result width in bits.
- ENGINE_FRACT_WIDTH, 20, fractional bits (informational; scaling is done by the external multiplier).
- ID_WIDTH, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), width of the requester ID.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*ENGINE_DATA_WIDTH  operand a, requester i in slice [i*W +: W].
- req_b  in  NUM_REQ*ENGINE_DATA_WIDTH  operand b, same packing.
- req_ready  out  NUM_REQ  one-hot (or zero) accept, combinational.
- mul_a  out  ENGINE_DATA_WIDTH  registered operand a to shared multiplier.
- mul_b  out  ENGINE_DATA_WIDTH  registered operand b to shared multiplier.
- mul_result  in  ENGINE_DATA_WIDTH  combinational product from shared multiplier.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  ENGINE_DATA_WIDTH  registered product.
- resp_id  out  ID_WIDTH  index of the requester that owns resp_data.
- busy  out  1  s1_valid | resp_valid.

Behaviour:
- Stages:
  - S1 holds s1_valid, mul_a, mul_b and s1_id.
  - S2 holds resp_valid, resp_data and resp_id.
- Reset (async, any time, including mid-operation):
  - s1_valid=0, resp_valid=0.
  - mul_a, mul_b, resp_data, resp_id = 0.
  - RR pointer=0.
  - In-flight operations are discarded and not replayed.
- S2 advance: s2_adv = s1_valid & (!resp_valid | resp_ready). On s2_adv, resp_data<=mul_result, resp_id<=s1_id, resp_valid<=1.
- S2 drain: if resp_valid & resp_ready & !s2_adv, resp_valid<=0.
- Stall: if resp_valid & !resp_ready, S2 holds. resp_data and resp_id must stay stable while resp_valid=1 and resp_ready=0.
- S1 free: s1_free = !s1_valid | s2_adv.
- Arbitration (combinational):
  - When s1_free, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = one-hot(grant) when s1_free and any req_valid, otherwise 0.
  - req_ready never depends on req_a or req_b.
- On accept (req_valid[g] & req_ready[g]):
  - mul_a<=req_a[g], mul_b<=req_b[g], s1_id<=g, s1_valid<=1.
  - ptr<=(g+1) mod NUM_REQ.
- With no accept and s2_adv, s1_valid<=0. With no accept, ptr holds.
- Throughput and latency:
  - With resp_ready=1, one op per cycle; accept at edge k gives resp_valid=1 after edge k+1 (latency 2 edges).
  - Back-to-back accepts from the same or different requesters are allowed.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ accepts.
- A requester may drop req_valid without acceptance; that has no effect on state.
- Arithmetic: no modification of mul_result. Width and truncation are owned by the multiplier; this block is a pure scheduler.
- NUM_REQ=1: ptr is constant 0, resp_id=0.

Optional Feature:
- Macro: MULT_RR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs op_count[15:0] (increments on each S2 advance) and stall_count[15:0] (increments on each cycle with resp_valid & !resp_ready).
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: requester 2 sends a=0x180000 (1.5), b=0x200000 (2.0), resp_ready=1.
  - Required: req_ready=4'b0100 in that cycle; resp_valid=1, resp_data=0x300000, resp_id=2 two edges after accept.
- Full contention: all four req_valid=1 for 8 cycles, resp_ready=1.
  - Required: resp_id sequence 0,1,2,3,0,1,2,3; one result per cycle.
- Backpressure: resp_ready=0 for 5 cycles with two ops in flight.
  - Required: resp_data/resp_id stable; S1 full; req_ready=0.
  - After resp_ready=1, both results delivered in order on consecutive cycles with no loss or duplication.
- Pointer wrap and skip: ptr=3, only req_valid[1]=1.
  - Required: grant 1, ptr becomes 2. Next grant with requesters 0 and 2 valid goes to 2.
- Reset mid-operation: assert rst asynchronously (between edges) with S1 and S2 full.
  - Required: resp_valid=0 and busy=0 immediately; after release the first grant honours ptr=0.
- Stats (MULT_RR_ARBITER_STATS_EN): 3 completed ops and 4 stall cycles.
  - Required: op_count=3, stall_count=4.
  - Forced to 16'hFFFF: stays at 16'hFFFF on further events.
